mem_port_arbiter: RTL

Shares one single-ported, multi-cycle unified memory between the instruction-fetch port and the data-memory port of the five-stage DLX pipeline. It sequences each access through a small state machine. It returns read data with a one-cycle acknowledge pulse, and the pipeline uses the pending-but-unacknowledged request as its stall condition. It also counts fetch cycles lost to data-port contention.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals shared by the
// unified-memory arbiter and its surroundings.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    modport slave (
        input  if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata,
               conflict_cnt
    );

    modport master (
        output if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata,
               conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the DLX fetch and data ports onto one multi-cycle unified memory,
// data port first, and counts fetch cycles lost to data-port contention.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DM_ACC
    } state_t;

    localparam logic [2:0] LAST = 3'(LATENCY - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       if_eff;
    logic       dm_eff;
    logic       conflict;

    // A requester is masked during its own ack cycle so it is not re-granted.
    assign if_eff   = bus.if_req & ~bus.if_ack & ~bus.if_kill;
    assign dm_eff   = bus.dm_req & ~bus.dm_ack;
    assign conflict = bus.if_req & ~bus.if_kill & ~bus.if_ack &
                      ((state == DM_ACC) | ((state == IDLE) & dm_eff));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.mem_cs       <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.if_ack       <= 1'b0;
            bus.dm_ack       <= 1'b0;
            bus.if_rdata     <= '0;
            bus.dm_rdata     <= '0;
            bus.conflict_cnt <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            if (conflict && bus.conflict_cnt != '1) begin
                bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (dm_eff) begin
                        state         <= DM_ACC;
                        bus.mem_cs    <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        cnt           <= '0;
                    end else if (if_eff) begin
                        state        <= IF_ACC;
                        bus.mem_cs   <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.if_addr;
                        cnt          <= '0;
                    end
                end
                IF_ACC: begin
                    // A kill on the completion edge still wins: no capture, no ack.
                    if (bus.if_kill) begin
                        state      <= IDLE;
                        bus.mem_cs <= 1'b0;
                        bus.mem_we <= 1'b0;
                        cnt        <= '0;
                    end else if (cnt == LAST) begin
                        state        <= IDLE;
                        bus.mem_cs   <= 1'b0;
                        bus.mem_we   <= 1'b0;
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_ack   <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DM_ACC: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        bus.mem_cs <= 1'b0;
                        bus.mem_we <= 1'b0;
                        bus.dm_ack <= 1'b1;
                        cnt        <= '0;
                        if (!bus.mem_we) begin
                            bus.dm_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.mem_cs <= 1'b0;
                    bus.mem_we <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end
endmodule
